adder_tree_pipe: RTL and testbench

Parametrised, fully pipelined adder tree that sums N_IN operands of WIDTH bits each into one full-precision result. It has one register level per tree level and a valid/ready handshake with backpressure. Each transaction carries a signed/unsigned flag, so one instance serves both operand formats. It sits between operand producers and any downstream consumer that can stall, such as accumulators or output FIFOs.

---
 rtl/adder_tree_pipe_if.sv | 29 ++
 rtl/adder_tree_pipe.sv | 105 ++++++++++
 tb/tb_adder_tree_pipe.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_pipe_if.sv
// Operand/result handshake bundle for adder_tree_pipe.
//   in_data/in_signed/in_valid -> in_ready   : operand side (producer drives)
//   out_data/out_signed/out_valid <- out_ready : result side (consumer drives out_ready)
// slave is the adder side, master the producer/consumer side.
interface adder_tree_pipe_if #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 8
);
  localparam int OW = WIDTH + $clog2(N_IN);

  logic [N_IN*WIDTH-1:0] in_data;
  logic                  in_signed;
  logic                  in_valid;
  logic                  in_ready;
  logic [OW-1:0]         out_data;
  logic                  out_signed;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_signed, in_valid, out_ready,
    input  in_ready, out_data, out_signed, out_valid
  );

  modport slave (
    input  in_data, in_signed, in_valid, out_ready,
    output in_ready, out_data, out_signed, out_valid
  );
endinterface

// File: rtl/adder_tree_pipe.sv
// Fully pipelined adder tree: sums N_IN operands of WIDTH bits into an exact
// OW-bit result, one register level per tree level, valid/ready with stall.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : adder_tree_pipe_if.slave (operands in, sum out)
// Operands are extended to the full result width at the leaves; since the true
// sum always fits in OW bits, every partial sum computed modulo 2^OW is exact.

// One tree level: registers the pairwise sums of the previous level plus the
// valid and signed bits that travel with them.
module adder_tree_lvl #(
  parameter int N_OUT = 1,
  parameter int OW    = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        vi,
  input  logic                        si,
  input  logic [2*N_OUT-1:0][OW-1:0]  a,
  output logic                        vo,
  output logic                        so,
  output logic [N_OUT-1:0][OW-1:0]    s
);
  logic [N_OUT-1:0][OW-1:0] sum;

  for (genvar i = 0; i < N_OUT; i++) begin : g_pair
    assign sum[i] = a[2*i] + a[2*i+1];
  end

  // Data and signed bit only load for valid entries, so bubbles never
  // disturb the held output value.
  always_ff @(posedge clk) begin
    if (rst) begin
      vo <= 1'b0;
      so <= 1'b0;
      s  <= '0;
    end else if (en) begin
      vo <= vi;
      if (vi) begin
        so <= si;
        s  <= sum;
      end
    end
  end
endmodule

module adder_tree_pipe #(
  parameter int WIDTH  = 8,
  parameter int N_IN   = 8,
  parameter int LEVELS = $clog2(N_IN),
  parameter int OW     = WIDTH + LEVELS
) (
  input  logic             clk,
  input  logic             rst,
  adder_tree_pipe_if.slave bus
);
  logic                     en;
  logic [LEVELS:0]          vld_pipe;
  logic [LEVELS:0]          sgn_pipe;
  logic [N_IN-1:0][OW-1:0]  leaf;
  // Internal nodes in heap order: level l occupies [(N_IN>>l)-1 +: N_IN>>l],
  // so node[0] is the root and each level's children sit contiguously below.
  logic [N_IN-2:0][OW-1:0]  node;

  // Whole pipeline moves in lockstep; it only freezes when the final
  // stage holds a result the consumer is not taking.
  assign en           = !vld_pipe[LEVELS] || bus.out_ready;
  assign bus.in_ready = en && !rst;
  assign vld_pipe[0]  = bus.in_valid && bus.in_ready;
  assign sgn_pipe[0]  = bus.in_signed;

  for (genvar k = 0; k < N_IN; k++) begin : g_leaf
    logic [WIDTH-1:0] op;
    assign op      = bus.in_data[k*WIDTH +: WIDTH];
    assign leaf[k] = {{(OW-WIDTH){bus.in_signed & op[WIDTH-1]}}, op};
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int N = N_IN >> l;
    logic [2*N-1:0][OW-1:0] a;

    if (l == 1) begin : g_first
      assign a = leaf;
    end else begin : g_inner
      assign a = node[2*N-1 +: 2*N];
    end

    adder_tree_lvl #(.N_OUT(N), .OW(OW)) u_lvl (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .vi  (vld_pipe[l-1]),
      .si  (sgn_pipe[l-1]),
      .a   (a),
      .vo  (vld_pipe[l]),
      .so  (sgn_pipe[l]),
      .s   (node[N-1 +: N])
    );
  end

  assign bus.out_valid  = vld_pipe[LEVELS];
  assign bus.out_signed = sgn_pipe[LEVELS];
  assign bus.out_data   = node[0];
endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: WIDTH=8/N_IN=8 main instance plus a
// WIDTH=4/N_IN=2 instance for the single-level case.
module tb_adder_tree_pipe;
  localparam int OW  = 11;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adder_tree_pipe_if #(.WIDTH(8), .N_IN(8)) bus ();
  adder_tree_pipe_if #(.WIDTH(4), .N_IN(2)) bus2 ();

  adder_tree_pipe #(.WIDTH(8), .N_IN(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  adder_tree_pipe #(.WIDTH(4), .N_IN(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    logic          s;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [63:0]   d;
    logic          s;
    logic [OW-1:0] e;
  } vec_t;

  int            errs = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [OW-1:0] cur_e = '0;
  bit            lat_chk = 1'b0;
  bit            rand_bp = 1'b0;
  exp_t          q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer sum of the operands interpreted per the mode bit.
  function automatic logic [OW-1:0] ref_sum(input logic [63:0] d, input logic s);
    int         acc;
    logic [7:0] v;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      v = d[k*8 +: 8];
      acc += s ? int'($signed(v)) : int'(v);
    end
    return acc[OW-1:0];
  endfunction

  // Scoreboard: record accepted transactions, compare retired results in order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("sum", 32'(bus.out_data), 32'(e.d));
          chk("out_signed", 32'(bus.out_signed), 32'(e.s));
          if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'(LAT));
        end
      end
      if (!rst && bus.in_valid && bus.in_ready)
        q.push_back('{cur_e, bus.in_signed, cyc});
    end
  end

  // Random consumer stalls, only while enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called and returns at posedge+1; holds the offer until accepted.
  task automatic send(input logic [63:0] d, input logic s, input logic [OW-1:0] e);
    logic acc;
    acc = 1'b0;
    bus.in_data = d; bus.in_signed = s; bus.in_valid = 1'b1; cur_e = e;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string nm);
    idle(LAT + 4);
    chk(nm, 32'(q.size()), 32'd0);
  endtask

  initial begin
    vec_t        tbl[6];
    vec_t        t2[4];
    logic [63:0] d;
    logic        s;
    int          nv;

    bus.in_data = '0; bus.in_signed = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus2.in_data = '0; bus2.in_signed = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;

    tbl[0] = '{64'h0706050403020100, 1'b0, 11'h01C};
    tbl[1] = '{{8{8'h80}},           1'b1, 11'h400};
    tbl[2] = '{{8{8'h80}},           1'b0, 11'h400};
    tbl[3] = '{{8{8'hFF}},           1'b1, 11'h7F8};
    tbl[4] = '{{8{8'hFF}},           1'b0, 11'h7F8};
    tbl[5] = '{{8{8'h01}},           1'b1, 11'h008};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_signed", 32'(bus.out_signed), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed table, back-to-back, alternating modes
    lat_chk = 1'b1;
    for (int i = 0; i < 6; i++) send(tbl[i].d, tbl[i].s, tbl[i].e);
    drain("table_drain");

    // 20 random transactions on consecutive cycles
    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom}; s = 1'($urandom_range(0, 1));
      send(d, s, ref_sum(d, s));
    end
    drain("random_drain");
    lat_chk = 1'b0;

    // Directed 5-cycle stall with a result waiting and a new input offered
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom}; s = 1'($urandom_range(0, 1));
      send(d, s, ref_sum(d, s));
    end
    idle(1);
    d = {$urandom, $urandom}; s = 1'($urandom_range(0, 1));
    bus.out_ready = 1'b0;
    bus.in_data = d; bus.in_signed = s; bus.in_valid = 1'b1; cur_e = ref_sum(d, s);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      if (q.size() > 0) chk("stall_hold", 32'(bus.out_data), 32'(q[0].d));
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(d, s, ref_sum(d, s));
    drain("stall_drain");

    // Random gaps and random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      d = {$urandom, $urandom}; s = 1'($urandom_range(0, 1));
      send(d, s, ref_sum(d, s));
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    drain("randbp_drain");

    // Reset with two transactions in flight
    d = {$urandom, $urandom};
    send(d, 1'b0, ref_sum(d, 1'b0));
    send(d, 1'b1, ref_sum(d, 1'b1));
    bus.in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_release", 32'(bus.in_ready), 32'd1);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    chk("midrst_no_stale", 32'(nv), 32'd0);
    @(posedge clk); #1;
    lat_chk = 1'b1;
    send(tbl[3].d, tbl[3].s, tbl[3].e);
    drain("post_rst_drain");
    lat_chk = 1'b0;

    // Single-level tree: latency 1
    t2[0] = '{64'h77, 1'b1, 11'h00E};
    t2[1] = '{64'hFF, 1'b1, 11'h01E};
    t2[2] = '{64'hFF, 1'b0, 11'h01E};
    t2[3] = '{64'h88, 1'b1, 11'h010};
    for (int i = 0; i < 4; i++) begin
      bus2.in_data = t2[i].d[7:0]; bus2.in_signed = t2[i].s; bus2.in_valid = 1'b1;
      @(negedge clk);
      chk("n2_in_ready", 32'(bus2.in_ready), 32'd1);
      chk("n2_not_early", 32'(bus2.out_valid), 32'd0);
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      @(negedge clk);
      chk("n2_valid", 32'(bus2.out_valid), 32'd1);
      chk("n2_sum", 32'(bus2.out_data), 32'(t2[i].e[4:0]));
      chk("n2_signed", 32'(bus2.out_signed), 32'(t2[i].s));
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
